conv2d_stream_engine: RTL and testbench

//  Streaming KxK 2-D convolution engine with fused batch-norm scale/shift and leaky ReLU.

---
 rtl/conv_pkg.sv | 34 +++
 rtl/conv_line_buffer.sv | 60 ++++++
 rtl/conv2d_stream_engine.sv | 218 +++++++++++++++++++++
 tb/tb_conv2d_stream_engine.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types, constants and arithmetic helpers for the streaming 2-D convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Negative activations are divided by 2^LEAKY_SHIFT.
  localparam int LEAKY_SHIFT = 3;

  // Accumulator wide enough to sum every product without overflow.
  function automatic int acc_width(input int n, input int ch, input int k);
    return 2 * n + $clog2(ch * k * k);
  endfunction

  // Clamp a signed value to the range of a signed 'width'-bit number.
  function automatic logic signed [63:0] sat_n(input logic signed [63:0] value, input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) begin
      return max_v;
    end
    if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One channel of the window generator: K-1 circular row buffers indexed by column
// feed a KxK shift-register window. Window tap (r,x) sits at [(r*K+x)*N +: N];
// row K-1 is the current row, column K-1 is the newest pixel.
module conv_line_buffer #(
  parameter int N     = 16,
  parameter int MAX_W = 416,
  parameter int K     = 3
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(MAX_W+1)-1:0] col,
  input  logic [N-1:0]               din,
  output logic [K*K*N-1:0]           win
);

  // col_vec[r] is the pixel of window row r in the column being written
  logic [K-1:0][N-1:0]        col_vec;
  logic [K-1:0][K-1:0][N-1:0] win_q;
  logic [K-1:0][K-1:0][N-1:0] win_d;

  assign col_vec[K-1] = din;

  genvar gi;
  generate
    for (gi = 0; gi < K - 1; gi++) begin : g_row
      // row buffer gi holds the row that is gi+1 rows older than the current one
      logic [N-1:0] mem [MAX_W];

      assign col_vec[K-2-gi] = mem[col];

      // each accepted pixel pushes its column one row deeper into the buffers
      always_ff @(posedge clk) begin
        if (wr_en) begin
          mem[col] <= col_vec[K-1-gi];
        end
      end
    end
  endgenerate

  // shift the window left by one column and insert the new column on the right
  always_comb begin
    win_d = win_q;
    if (wr_en) begin
      for (int r = 0; r < K; r++) begin
        for (int x = 0; x < K - 1; x++) begin
          win_d[r][x] = win_q[r][x+1];
        end
        win_d[r][K-1] = col_vec[r];
      end
    end
  end

  // window register; contents are qualified by the valid tag in the top
  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  assign win = win_q;

endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming KxK multi-channel convolution with fused batch-norm scale/shift,
// leaky ReLU and saturation. Ready/valid on both sides; the whole pipeline
// stalls when the output register is full and not being drained.
module conv2d_stream_engine
  import conv_pkg::*;
#(
  parameter int N     = 16,
  parameter int Q     = 12,
  parameter int MAX_W = 416,
  parameter int MAX_H = 416,
  parameter int K     = 3,
  parameter int CH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(MAX_W+1)-1:0] img_w,
  input  logic [$clog2(MAX_H+1)-1:0] img_h,
  input  logic                       stride2,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CH*N-1:0]            in_data,
  input  logic [CH*K*K*N-1:0]        weight,
  input  logic [N-1:0]               gamma,
  input  logic [N-1:0]               beta,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_data,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);

  localparam int WW    = $clog2(MAX_W + 1);
  localparam int HW    = $clog2(MAX_H + 1);
  localparam int TAPS  = CH * K * K;
  localparam int ACC_W = acc_width(N, CH, K);
  localparam int BN_W  = ACC_W + N + 1;
  // parity that row-(K-1) / col-(K-1) must have to land on the stride-2 grid
  localparam logic ODD_OFF = 1'((K - 1) % 2);

  state_t          state_q, state_d;
  logic [WW-1:0]   col_q, col_d, img_w_q, img_w_d;
  logic [HW-1:0]   row_q, row_d, img_h_q, img_h_d;
  logic            stride2_q, stride2_d;
  logic            cfg_err_q, cfg_err_d;
  logic            v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic            out_valid_q, out_valid_d;
  logic [N-1:0]    out_q, out_d;

  logic signed [2*N-1:0]    prod_q [TAPS];
  logic signed [2*N-1:0]    prod_d [TAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [BN_W-1:0]   bn_q, bn_d;
  logic signed [ACC_W-1:0]  sum_c;
  logic signed [ACC_W+N-1:0] scaled_c;
  logic signed [BN_W-1:0]   leaky_c;

  logic            ce, accept, win_ok, cfg_bad, last_col, last_px;
  logic [TAPS*N-1:0] win_all;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      conv_line_buffer #(.N(N), .MAX_W(MAX_W), .K(K)) u_lb (
        .clk   (clk),
        .wr_en (accept),
        .col   (col_q),
        .din   (in_data[gi*N +: N]),
        .win   (win_all[gi*K*K*N +: K*K*N])
      );
    end
  endgenerate

  // handshake, config check and window-valid decode for the pixel on the input
  always_comb begin
    ce       = !out_valid_q || out_ready;
    accept   = in_valid && (state_q == RUN) && ce;
    cfg_bad  = (img_w < WW'(K)) || (img_w > WW'(MAX_W)) ||
               (img_h < HW'(K)) || (img_h > HW'(MAX_H));
    last_col = (col_q == img_w_q - WW'(1));
    last_px  = last_col && (row_q == img_h_q - HW'(1));
    win_ok   = (row_q >= HW'(K - 1)) && (col_q >= WW'(K - 1)) &&
               (!stride2_q || ((row_q[0] == ODD_OFF) && (col_q[0] == ODD_OFF)));
  end

  // valid tags travel alongside the data and advance only on ce
  always_comb begin
    v0_d        = v0_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    v3_d        = v3_q;
    out_valid_d = out_valid_q;
    if (ce) begin
      v0_d        = accept && win_ok;
      v1_d        = v0_q;
      v2_d        = v1_q;
      v3_d        = v2_q;
      out_valid_d = v3_q;
    end
  end

  // frame control: config latch, raster counters, drain detection
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    img_w_d   = img_w_q;
    img_h_d   = img_h_q;
    stride2_d = stride2_q;
    cfg_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            img_w_d   = img_w;
            img_h_d   = img_h;
            stride2_d = stride2;
            col_d     = '0;
            row_d     = '0;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        if (accept) begin
          if (last_col) begin
            col_d = '0;
            row_d = row_q + HW'(1);
          end else begin
            col_d = col_q + WW'(1);
          end
          if (last_px) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // finishing as soon as the pipeline will be empty lets done follow the last handshake directly
        if (!(v0_d || v1_d || v2_d || v3_d || out_valid_d)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // MAC, batch-norm and activation datapath; every stage holds while ce is low
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < TAPS; i++) begin
      prod_d[i] = ce ? ($signed(win_all[i*N +: N]) * $signed(weight[i*N +: N])) : prod_q[i];
      sum_c     = sum_c + ACC_W'(prod_q[i]);
    end
    acc_d    = ce ? (sum_c >>> Q) : acc_q;
    scaled_c = acc_q * $signed(gamma);
    bn_d     = ce ? (BN_W'(scaled_c >>> Q) + BN_W'($signed(beta))) : bn_q;
    leaky_c  = bn_q[BN_W-1] ? (bn_q >>> LEAKY_SHIFT) : bn_q;
    out_d    = (ce && v3_q) ? N'(sat_n(64'(leaky_c), N)) : out_q;
  end

  // control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      img_w_q     <= '0;
      img_h_q     <= '0;
      stride2_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      img_w_q     <= img_w_d;
      img_h_q     <= img_h_d;
      stride2_q   <= stride2_d;
      cfg_err_q   <= cfg_err_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  // datapath registers need no reset; their contents are qualified by the valid tags
  always_ff @(posedge clk) begin
    for (int i = 0; i < TAPS; i++) begin
      prod_q[i] <= prod_d[i];
    end
    acc_q <= acc_d;
    bn_q  <= bn_d;
  end

  assign in_ready  = (state_q == RUN) && ce;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Self-checking bench: config table, fixed scenario table, reset abort and
// randomized frames compared against a frame-level arithmetic reference.
`timescale 1ns/1ps
module tb_conv2d_stream_engine;

  localparam int N      = 16;
  localparam int Q      = 12;
  localparam int MAX_W  = 416;
  localparam int MAX_H  = 416;
  localparam int K      = 3;
  localparam int CH     = 4;
  localparam int WW     = $clog2(MAX_W + 1);
  localparam int HW     = $clog2(MAX_H + 1);
  localparam int MAXPIX = 144;

  logic clk = 1'b0;
  logic rst, start, stride2, in_valid, in_ready, out_valid, out_ready, busy, done, cfg_err;
  logic [WW-1:0]         img_w;
  logic [HW-1:0]         img_h;
  logic [CH*N-1:0]       in_data;
  logic [CH*K*K*N-1:0]   weight;
  logic [N-1:0]          gamma, beta, out_data;

  int n_cmp = 0;
  int n_err = 0;
  int pix [CH][MAXPIX];
  int wt [CH*K*K];
  int gam, bet;
  int exp_q[$];

  typedef struct { int w; int h; bit err; } cfg_vec_t;
  typedef struct { int w; int h; int s; int ch0; int oth; int exp_val; int exp_cnt; int rmode; } scen_t;

  always #5 clk = ~clk;

  conv2d_stream_engine #(.N(N), .Q(Q), .MAX_W(MAX_W), .MAX_H(MAX_H), .K(K), .CH(CH)) dut (
    .clk(clk), .rst(rst), .start(start), .img_w(img_w), .img_h(img_h), .stride2(stride2),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .weight(weight),
    .gamma(gamma), .beta(beta), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_params();
    for (int i = 0; i < CH*K*K; i++) weight[i*N +: N] = N'(wt[i]);
    gamma = N'(gam);
    beta  = N'(bet);
  endtask

  task automatic fill_const(input int ch0, input int oth, input int w, input int h);
    for (int c = 0; c < CH; c++)
      for (int p = 0; p < w*h; p++) pix[c][p] = (c == 0) ? ch0 : oth;
    for (int i = 0; i < CH*K*K; i++) wt[i] = 4096;
    gam = 4096;
    bet = 0;
    load_params();
  endtask

  // Reference: evaluate every window of the stored frame directly with integer arithmetic.
  function automatic void build_model(input int w, input int h, input int s);
    longint acc, bn;
    exp_q.delete();
    for (int oy = 0; oy*s + K <= h; oy++) begin
      for (int ox = 0; ox*s + K <= w; ox++) begin
        acc = 0;
        for (int c = 0; c < CH; c++)
          for (int r = 0; r < K; r++)
            for (int x = 0; x < K; x++)
              acc = acc + longint'(pix[c][(oy*s + r)*w + ox*s + x]) * longint'(wt[(c*K + r)*K + x]);
        acc = acc >>> Q;
        bn  = ((acc * longint'(gam)) >>> Q) + longint'(bet);
        if (bn < 0) bn = bn >>> 3;
        if (bn > 32767) bn = 32767;
        if (bn < -32768) bn = -32768;
        exp_q.push_back(int'(bn));
      end
    end
  endfunction

  // Drive one frame and score it. exp_cnt>=0 selects a fixed expected value,
  // otherwise the reference model supplies the expected stream.
  task automatic run_frame(input string tag, input int w, input int h, input int s,
                           input int vpct, input int rmode, input int abort_at,
                           input int exp_val, input int exp_cnt, input bit chk_lat);
    int idx, cyc, last_hs, done_cyc, n_done, n_out, budget;
    bit prev_stall, finished, aborted, seen;
    logic [N-1:0] prev_data;
    if (exp_cnt >= 0) begin
      exp_q.delete();
      for (int i = 0; i < exp_cnt; i++) exp_q.push_back(exp_val);
    end else begin
      build_model(w, h, s);
    end
    @(negedge clk);
    img_w = WW'(w); img_h = HW'(h); stride2 = (s == 2); start = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // changing the cfg inputs after start must not affect the running frame
    img_w = WW'(K); img_h = HW'(K); stride2 = ~stride2;
    #1;
    check("busy_after_start", longint'(busy), 1);
    idx = 0; cyc = 0; last_hs = -1; done_cyc = -1; n_done = 0; n_out = 0;
    prev_stall = 1'b0; prev_data = '0; finished = 1'b0; aborted = 1'b0;
    budget = 20*w*h + 200;
    while (!finished && cyc < budget) begin
      if (idx < w*h) begin
        in_valid = ($urandom_range(99) < vpct);
        for (int c = 0; c < CH; c++) in_data[c*N +: N] = N'(pix[c][idx]);
      end else begin
        in_valid = $urandom_range(1) == 1;
        in_data  = {CH{N'($urandom)}};
      end
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(3) != 0);
        default: out_ready = !(cyc >= 20 && cyc < 30);
      endcase
      start = (cyc == 3);  // start while busy must be ignored
      #1;
      if (prev_stall) begin
        check("stall_hold_valid", longint'(out_valid), 1);
        check("stall_hold_data", longint'($signed(out_data)), longint'($signed(prev_data)));
      end
      if (out_valid && !out_ready) check("stall_in_ready", longint'(in_ready), 0);
      if (idx == w*h) check("in_ready_after_last", longint'(in_ready), 0);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_output", 1, 0);
        else check("out_data", longint'($signed(out_data)), longint'(exp_q.pop_front()));
        last_hs = cyc;
        n_out++;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (abort_at >= 0 && idx == abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) finished = 1'b1;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (aborted) begin
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_busy", longint'(busy), 0);
      check("abort_out_valid", longint'(out_valid), 0);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        #1;
        if (done) seen = 1'b1;
      end
      check("abort_no_done", longint'(seen), 0);
      $display("frame %s w=%0d h=%0d s=%0d aborted after %0d pixels", tag, w, h, s, idx);
      return;
    end
    check("frame_finished", longint'(finished), 1);
    check("done_pulses", n_done, 1);
    check("outputs_missing", exp_q.size(), 0);
    check("busy_after_done", longint'(busy), 0);
    if (chk_lat && done_cyc >= 0) check("done_latency", done_cyc - last_hs, 1);
    $display("frame %s w=%0d h=%0d s=%0d outputs=%0d done_cycle=%0d", tag, w, h, s, n_out, done_cyc);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_vec_t cfg_tbl [6];
    scen_t    scen [5];
    int w, h, s, big;
    cfg_tbl[0] = '{2, 5, 1'b1};
    cfg_tbl[1] = '{5, 2, 1'b1};
    cfg_tbl[2] = '{417, 5, 1'b1};
    cfg_tbl[3] = '{5, 417, 1'b1};
    cfg_tbl[4] = '{3, 3, 1'b0};
    cfg_tbl[5] = '{416, 416, 1'b0};
    scen[0] = '{5, 5, 1,  1024,    0,  9216, 9, 0};
    scen[1] = '{5, 5, 2,  1024,    0,  9216, 4, 0};
    scen[2] = '{5, 5, 1, -1024,    0, -1152, 9, 0};
    scen[3] = '{5, 5, 1,  4096, 4096, 32767, 9, 0};
    scen[4] = '{5, 5, 1,  1024,    0,  9216, 9, 2};

    rst = 1'b1; start = 1'b0; img_w = '0; img_h = '0; stride2 = 1'b0;
    in_valid = 1'b0; in_data = '0; weight = '0; gamma = '0; beta = '0; out_ready = 1'b1;

    do_reset();
    #1;
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_cfg_err", longint'(cfg_err), 0);
    check("rst_out_data", longint'(out_data), 0);

    // configuration acceptance table
    for (int i = 0; i < 6; i++) begin
      do_reset();
      img_w = WW'(cfg_tbl[i].w); img_h = HW'(cfg_tbl[i].h); stride2 = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("cfg_err_pulse", longint'(cfg_err), longint'(cfg_tbl[i].err));
      check("cfg_busy", longint'(busy), longint'(!cfg_tbl[i].err));
      @(negedge clk);
      #1;
      check("cfg_err_clear", longint'(cfg_err), 0);
      $display("cfg w=%0d h=%0d cfg_err=%0d busy=%0d", cfg_tbl[i].w, cfg_tbl[i].h, cfg_err, busy);
    end

    // fixed scenarios with hand-computed results
    for (int i = 0; i < 5; i++) begin
      do_reset();
      fill_const(scen[i].ch0, scen[i].oth, scen[i].w, scen[i].h);
      run_frame($sformatf("scen%0d", i + 1), scen[i].w, scen[i].h, scen[i].s, 100,
                scen[i].rmode, -1, scen[i].exp_val, scen[i].exp_cnt, 1'b1);
    end

    // reset in the middle of a frame, then a clean frame
    do_reset();
    fill_const(1024, 0, 5, 5);
    run_frame("abort", 5, 5, 1, 100, 0, 12, 9216, 9, 1'b0);
    do_reset();
    fill_const(1024, 0, 5, 5);
    run_frame("after_abort", 5, 5, 1, 100, 0, -1, 9216, 9, 1'b1);

    // randomized frames against the reference model
    for (int f = 0; f < 24; f++) begin
      w = $urandom_range(K, 9);
      h = $urandom_range(K, 9);
      s = $urandom_range(1, 2);
      big = $urandom_range(1);
      for (int c = 0; c < CH; c++)
        for (int p = 0; p < w*h; p++)
          pix[c][p] = big ? (int'($urandom_range(65535)) - 32768) : (int'($urandom_range(4095)) - 2048);
      for (int i = 0; i < CH*K*K; i++)
        wt[i] = big ? (int'($urandom_range(65535)) - 32768) : (int'($urandom_range(2047)) - 1024);
      gam = int'($urandom_range(65535)) - 32768;
      bet = int'($urandom_range(65535)) - 32768;
      load_params();
      do_reset();
      run_frame($sformatf("rand%0d", f), w, h, s, (f % 2 == 0) ? 100 : 65,
                int'($urandom_range(1)), -1, 0, -1,
                ((w - K) % s == 0) && ((h - K) % s == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
